// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring integer divider. Signed or unsigned,
//            one quotient bit per cycle, valid/ready on input and output,
//            and a pipeline cancel input.
// Config   : DIV_ZERO_SHORTCUT_EN - when defined, a zero divisor skips the
//            iteration loop and the result is presented one cycle after the
//            handshake. Result values do not change.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;        // remaining dividend bits, consumed MSB first
  logic [WIDTH-1:0] dvs_q;        // divisor magnitude
  logic [WIDTH-1:0] prem_q;       // partial remainder
  logic [WIDTH-1:0] quo_q;        // quotient magnitude being assembled
  logic [WIDTH-1:0] orig_q;       // untouched dividend for the divide-by-zero result
  logic             qsign_q;
  logic             rsign_q;
  logic             zero_q;       // divisor was zero at the handshake
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] w_qfix;
  logic [WIDTH-1:0] w_rfix;
  logic             w_last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Operand magnitudes, one restoring step and the final sign fix-up.
  always_comb begin
    w_dvd_neg = in_signed & dividend[WIDTH-1];
    w_dvs_neg = in_signed & divisor[WIDTH-1];
    w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    w_dvs_abs = w_dvs_neg ? -divisor  : divisor;

    // The partial remainder is always below the divisor, so one extra bit
    // is enough for the trial subtraction; its top bit is the borrow.
    w_shift = {prem_q, dvd_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, dvs_q};
    prem_d  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};

    w_qfix = qsign_q ? -quo_q  : quo_q;
    w_rfix = rsign_q ? -prem_q : prem_q;

`ifdef DIV_ZERO_SHORTCUT_EN
    w_last = (cnt_q == CW'(WIDTH)) || zero_q;
`else
    w_last = (cnt_q == CW'(WIDTH));
`endif
  end

  // Control FSM and datapath registers: reset, then cancel, then normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      orig_q      <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (cancel) begin
      // Result registers keep their last contents; only the handshake drops.
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q   <= w_dvd_abs;
            dvs_q   <= w_dvs_abs;
            prem_q  <= '0;
            quo_q   <= '0;
            orig_q  <= dividend;
            qsign_q <= w_dvd_neg ^ w_dvs_neg;
            rsign_q <= w_dvd_neg;
            zero_q  <= (divisor == '0);
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (w_last) begin
            // Divide by zero bypasses sign correction entirely.
            quotient_q  <= zero_q ? '1     : w_qfix;
            remainder_q <= zero_q ? orig_q : w_rfix;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            prem_q <= prem_d;
            quo_q  <= quo_d;
            dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Purpose  : Scoreboard bench for div_iter with a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, in_signed, cancel;
  logic         out_valid, out_ready;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  logic [63:0]  exp_q[$];
  logic [31:0]  last_q, last_r;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Truncating division computed in 64-bit arithmetic.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint      x, y, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q  = x / y;
    r  = x % y;
    qv = q;
    rv = r;
    return {qv[31:0], rv[31:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: every output transfer is compared with the oldest expectation.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h/%h required=none", quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        check("sb_quotient", quotient, e[63:32]);
        check("sb_remainder", remainder, e[31:0]);
      end
      last_q = quotient;
      last_r = remainder;
      n_out++;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) fail_now("wait_in_ready");
  endtask

  // Handshake one operation; returns 1 ns after the accepting edge.
  task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    in_valid  = 1'b1;
    in_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    exp_q.push_back(model(sgn, a, b));
    #1;
    in_valid  = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    in_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (out_valid !== 1'b1) fail_now("wait_out_valid");
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    while (out_valid === 1'b1 && n < 60) begin
      out_ready = (rnd && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b1;
    if (out_valid === 1'b1) fail_now("drain");
  endtask

  typedef struct {
    bit          sgn;
    logic [31:0] a, b, q, r;
  } vec_t;

  vec_t vecs[6] = '{
    '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001},
    '{1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001},
    '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000},
    '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005},
    '{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB}
  };

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          lat;
    int          seen;
    logic [31:0] a, b;
    bit          s;

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    cancel    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    check("rst_no_accept", 32'(in_ready), 32'd1);

    // Basic unsigned case with latency and turnaround.
    start_op(1'b0, 32'd100, 32'd7);
    wait_valid(lat);
    check("lat_100_7", lat, 32'd33);
    drain(1'b0);
    check("ready_after_xfer", 32'(in_ready), 32'd1);
    check("q_100_7", last_q, 32'd14);
    check("r_100_7", last_r, 32'd2);

    // Signed corners, overflow and divide by zero.
    foreach (vecs[i]) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check("dir_latency", lat, (vecs[i].b == 32'd0) ? ZLAT : 33);
      drain(1'b0);
      check("dir_quotient", last_q, vecs[i].q);
      check("dir_remainder", last_r, vecs[i].r);
    end

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    start_op(1'b0, 32'd1000, 32'd3);
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", quotient, 32'd333);
      check("bp_remainder", remainder, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(in_ready), 32'd1);

    // Cancel in the middle of the iteration loop.
    seen = n_out;
    start_op(1'b0, 32'd12345, 32'd67);
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    void'(exp_q.pop_back());
    check("cx_calc_ready", 32'(in_ready), 32'd1);
    check("cx_calc_valid", 32'(out_valid), 32'd0);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) lat++;
    end
    check("cx_calc_no_out", lat, 32'd0);
    check("cx_calc_no_xfer", n_out - seen, 32'd0);
    start_op(1'b0, 32'd9, 32'd3);
    wait_valid(lat);
    check("lat_9_3", lat, 32'd33);
    drain(1'b0);
    check("q_9_3", last_q, 32'd3);
    check("r_9_3", last_r, 32'd0);

    // Cancel while the result is waiting for the consumer.
    out_ready = 1'b0;
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_valid(lat);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    void'(exp_q.pop_back());
    check("cx_done_valid", 32'(out_valid), 32'd0);
    check("cx_done_ready", 32'(in_ready), 32'd1);
    check("cx_done_q_kept", quotient, 32'hFFFF_FFF2);
    check("cx_done_r_kept", remainder, 32'hFFFF_FFFE);
    out_ready = 1'b1;

    // Reset in the middle of the iteration loop, with in_valid asserted.
    seen = n_out;
    start_op(1'b0, 32'd500, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd7;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    check("rc_in_ready", 32'(in_ready), 32'd1);
    check("rc_out_valid", 32'(out_valid), 32'd0);
    check("rc_quotient", quotient, 32'd0);
    check("rc_remainder", remainder, 32'd0);
    @(posedge clk); #1;
    check("rc_no_accept", 32'(in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("rc_no_xfer", n_out - seen, 32'd0);

    // Randomised operations with random consumer stalls.
    for (int k = 0; k < 150; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 15);
        4: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
        default: ;
      endcase
      start_op(s, a, b);
      wait_valid(lat);
      check("rnd_latency", lat, (b == 32'd0) ? ZLAT : 33);
      drain(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
